arb_req_agent: RTL

ARB_REQ_AGENT -- requirements
Module: arb_req_agent

---
 rtl/arb_req_agent_pkg.sv | 13 +
 rtl/arb_req_agent_onehot_enc.sv | 23 ++
 rtl/arb_req_agent.sv | 131 +++++++++++++
 3 files changed

// File: rtl/arb_req_agent_pkg.sv
// Shared definitions for the arbitrated request agent: parameter defaults and FSM state encoding.
package arb_req_agent_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned CNT_W       = 16;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t LOCK = 1'b1;

endpackage

// File: rtl/arb_req_agent_onehot_enc.sv
// Converts a grant vector to a channel index and flags whether exactly one bit is set.
module onehot_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic [IdxW-1:0] idx_c,
    output logic            onehot_c
);

    // OR of set-bit indices; only meaningful when onehot_c is high
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx_c = idx_c | IdxW'(i);
            end
        end
    end

    assign onehot_c = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/arb_req_agent.sv
// Requests a channel from an external round-robin arbiter, locks onto it for a whole
// packet and forwards its beats through a single registered output stage.
module arb_req_agent
    import arb_req_agent_pkg::*;
#(
    parameter int unsigned NumReq = NUM_REQ_DEF,
    parameter int unsigned DataW  = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NumReq-1:0]          in_valid,
    input  logic [NumReq*DataW-1:0]    in_data,
    input  logic [NumReq-1:0]          in_last,
    output logic [NumReq-1:0]          in_ready,
    output logic [NumReq-1:0]          req,
    input  logic [NumReq-1:0]          grant,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DataW-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(NumReq)-1:0]  out_chan,
    output logic                       grant_err,
    output logic [CNT_W-1:0]           pkt_cnt
);

    localparam int unsigned ChanW = $clog2(NumReq);

    state_t             state;
    state_t             state_nxt;
    logic [ChanW-1:0]   owner;
    logic [ChanW-1:0]   owner_nxt;
    logic               err_nxt;
    logic [ChanW-1:0]   gnt_idx;
    logic               gnt_onehot;
    logic               gnt_ok;
    logic               gnt_bad;
    logic               can_load;
    logic               accept;
    logic               own_valid;
    logic               own_last;
    logic [DataW-1:0]   own_data;

    onehot_enc #(
        .N    (NumReq),
        .IdxW (ChanW)
    ) u_enc (
        .vec      (grant),
        .idx_c    (gnt_idx),
        .onehot_c (gnt_onehot)
    );

    assign own_valid = in_valid[owner];
    assign own_last  = in_last[owner];
    assign own_data  = in_data[owner*DataW +: DataW];

    // A grant is only usable if it names exactly one channel that is actually requesting
    assign gnt_ok   = gnt_onehot && ((grant & in_valid) != '0);
    assign gnt_bad  = (grant != '0) && !gnt_ok;
    assign can_load = !out_valid || out_ready;
    assign accept   = (state == LOCK) && own_valid && can_load;

    // Requests are withheld while locked so the arbiter pointer moves only on acquisition
    assign req = (!rst && (state == IDLE)) ? in_valid : '0;

    always_comb begin
        in_ready = '0;
        if (!rst && (state == LOCK) && can_load) begin
            in_ready[owner] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_ok) begin
                    state_nxt = LOCK;
                    owner_nxt = gnt_idx;
                end else if (gnt_bad) begin
                    err_nxt = 1'b1;
                end
            end
            LOCK: begin
                if (accept && own_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            grant_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            grant_err <= err_nxt;
        end
    end

    // Output stage: load on accept, drop valid once the held beat is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= own_data;
            out_last  <= own_last;
            out_chan  <= owner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (accept && own_last) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end

endmodule
